// File: rtl/intr432_pkg.sv
// Shared types for the 27-channel interrupt service sequencer.
package intr432_pkg;

    localparam int NCH = 9;

    typedef enum logic [1:0] {
        GRP_NONE = 2'b00,
        GRP_A    = 2'b01,
        GRP_B    = 2'b10,
        GRP_C    = 2'b11
    } grp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_CLEAR,
        ST_RELEASE
    } state_e;

    typedef struct packed {
        grp_e       grp;
        logic [3:0] idx;
    } vec_t;

    // One-hot mask for a channel index within a group.
    function automatic logic [NCH-1:0] chan_mask(input logic [3:0] idx);
        logic [NCH-1:0] one;
        one = {{(NCH-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/req_latch432.sv
// One group's bank of request latches: pulses set bits, service clears them.
module req_latch432
    import intr432_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] set,
    input  logic [NCH-1:0] clr,
    output logic [NCH-1:0] q
);

    // Set dominates clear, so a fresh pulse on the serviced bit is kept.
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= (q & ~clr) | set;
    end

endmodule

// File: rtl/intr_service_seq432.sv
// Service sequencer: latches requests, takes the controller's winner and
// runs the irq/ack handshake, clearing the serviced bit after each ack.
module intr_service_seq432
    import intr432_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] set_a_i,
    input  logic [NCH-1:0] set_b_i,
    input  logic [NCH-1:0] set_c_i,
    output logic [NCH-1:0] req_a_o,
    output logic [NCH-1:0] req_b_o,
    output logic [NCH-1:0] req_c_o,
    input  logic           pa_i,
    input  logic           pb_i,
    input  logic           pc_i,
    input  logic [3:0]     chan_i,
    output logic           irq_o,
    output logic [5:0]     vec_o,
    input  logic           ack_i,
    output logic           err_o
);

    localparam int             CW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};
    localparam logic [3:0]     CHAN_MAX = 4'(NCH - 1);

    state_e                   state;
    vec_t                     vec_q;
    logic [CW-1:0]            cnt;
    logic                     irq_q;
    logic                     err_q;
    grp_e                     win_grp;
    logic [2:0][NCH-1:0]      set_g;
    logic [2:0][NCH-1:0]      clr_g;
    logic [2:0][NCH-1:0]      req_g;

    assign set_g = {set_c_i, set_b_i, set_a_i};

    // One latch bank per group (index 0 = A, 1 = B, 2 = C).
    for (genvar g = 0; g < 3; g++) begin : g_lat
        req_latch432 u_lat (
            .clk (clk),
            .rst (rst),
            .set (set_g[g]),
            .clr (clr_g[g]),
            .q   (req_g[g])
        );
    end

    assign req_a_o = req_g[0];
    assign req_b_o = req_g[1];
    assign req_c_o = req_g[2];

    // Group decode: A beats B beats C.
    always_comb begin
        win_grp = GRP_NONE;
        if (pa_i)      win_grp = GRP_A;
        else if (pb_i) win_grp = GRP_B;
        else if (pc_i) win_grp = GRP_C;
    end

    // Clear the serviced bit only during the single CLEAR cycle.
    always_comb begin
        clr_g = '0;
        if (state == ST_CLEAR) begin
            case (vec_q.grp)
                GRP_A:   clr_g[0] = chan_mask(vec_q.idx);
                GRP_B:   clr_g[1] = chan_mask(vec_q.idx);
                GRP_C:   clr_g[2] = chan_mask(vec_q.idx);
                default: clr_g    = '0;
            endcase
        end
    end

    // Handshake FSM with registered irq/err and a saturating ack timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            vec_q <= '0;
            cnt   <= '0;
            irq_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_grp != GRP_NONE) begin
                        if (chan_i <= CHAN_MAX) begin
                            vec_q <= {win_grp, chan_i};
                            cnt   <= '0;
                            irq_q <= 1'b1;
                            state <= ST_ASSERT;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_ASSERT: begin
                    if (ack_i) begin
                        irq_q <= 1'b0;
                        state <= ST_CLEAR;
                    end else if (cnt == CNT_LAST) begin
                        // Abandon but keep the latch so re-arbitration can retry.
                        irq_q <= 1'b0;
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!ack_i) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign irq_o = irq_q;
    assign vec_o = vec_q;
    assign err_o = err_q;

endmodule
